// File: rtl/roundkey_read_from_ram.sv
// roundkey_read_from_ram
//
// Reads expanded round keys 0..R back out of either the encrypt (Ke) or
// decrypt (Kd) four-bank key RAM and streams them, one 128-bit key per
// round index in ascending address order, to the round datapath.
// A small return FIFO absorbs the RAM read latency and consumer stalls;
// reads are only issued while a FIFO slot is guaranteed for the data.
//
// Handshake: a key transfers on a cycle where oValid & iReady are both 1.
// While oValid=1 and iReady=0, oKey/oKey_idx hold their value.
//
// Ports:
//   iClk, iRst_n          clock, synchronous active-low reset
//   iStart                one-cycle start pulse (ignored while oBusy)
//   iDecrypt, iRound      bank select and last round index, latched at start
//   oBusy, oDone          busy level, one-cycle completion pulse
//   oRAM_Ke_*/iRAM_Ke_q_* encrypt key RAM read port (4 banks)
//   oRAM_Kd_*/iRAM_Kd_q_* decrypt key RAM read port (4 banks)
//   oKey, oKey_idx        presented key and the RAM address it came from
//   oValid, iReady        key stream handshake
//   oDbg_state            current FSM state (IDLE=0, FETCH=1, DRAIN=2)
module roundkey_read_from_ram #(
    parameter int RD_LATENCY = 1
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    input  logic         iDecrypt,
    input  logic [3:0]   iRound,
    output logic         oBusy,
    output logic         oDone,
    output logic [3:0]   oRAM_Ke_addr,
    output logic         oRAM_Ke_read,
    input  logic [31:0]  iRAM_Ke_q_1,
    input  logic [31:0]  iRAM_Ke_q_2,
    input  logic [31:0]  iRAM_Ke_q_3,
    input  logic [31:0]  iRAM_Ke_q_4,
    output logic [3:0]   oRAM_Kd_addr,
    output logic         oRAM_Kd_read,
    input  logic [31:0]  iRAM_Kd_q_1,
    input  logic [31:0]  iRAM_Kd_q_2,
    input  logic [31:0]  iRAM_Kd_q_3,
    input  logic [31:0]  iRAM_Kd_q_4,
    output logic [127:0] oKey,
    output logic [3:0]   oKey_idx,
    output logic         oValid,
    input  logic         iReady,
    output logic [1:0]   oDbg_state
);

    localparam int         DEPTH     = RD_LATENCY + 1;
    localparam logic [1:0] LAST_SLOT = 2'(DEPTH - 1);
    localparam logic [2:0] DEPTH_W   = 3'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  dec_q, dec_d;
    logic [3:0]            round_q, round_d;
    logic [3:0]            addr_q, addr_d;
    logic                  done_q, done_d;

    // Read-return tracker: stage i set means a read issued i+1 cycles ago
    // whose data has not yet been captured.
    logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [3:0]            pipe_idx_q [RD_LATENCY];
    logic [3:0]            pipe_idx_d [RD_LATENCY];

    // Storage is four slots so the 2-bit pointers index it exactly; only
    // the first DEPTH slots are ever used.
    logic [127:0]          fifo_key_q [4];
    logic [127:0]          fifo_key_d [4];
    logic [3:0]            fifo_idx_q [4];
    logic [3:0]            fifo_idx_d [4];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic [2:0]            inflight;
    logic                  pop;
    logic                  issue;
    logic                  capture;
    logic [127:0]          rd_data;
    logic [3:0]            head_idx;
    logic [127:0]          head_key;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {2'b00, pipe_vld_q[i]};
        end
    end

    assign pop      = (count_q != 2'd0) && iReady;
    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign head_key = fifo_key_q[rd_ptr_q];
    assign capture  = pipe_vld_q[RD_LATENCY-1];
    assign rd_data  = dec_q ? {iRAM_Kd_q_1, iRAM_Kd_q_2, iRAM_Kd_q_3, iRAM_Kd_q_4}
                            : {iRAM_Ke_q_1, iRAM_Ke_q_2, iRAM_Ke_q_3, iRAM_Ke_q_4};

    // Every issued read must find a FIFO slot when it returns; a slot freed
    // by this cycle's pop can be reused, which keeps one key per cycle.
    assign issue = (state_q == ST_FETCH) &&
                   ((inflight + {1'b0, count_q}) < (DEPTH_W + {2'b00, pop}));

    always_comb begin
        state_d    = state_q;
        dec_d      = dec_q;
        round_d    = round_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        pipe_vld_d = pipe_vld_q;
        pipe_idx_d = pipe_idx_q;
        fifo_key_d = fifo_key_q;
        fifo_idx_d = fifo_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        pipe_vld_d[0] = issue;
        pipe_idx_d[0] = addr_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end

        if (capture) begin
            fifo_key_d[wr_ptr_q] = rd_data;
            fifo_idx_d[wr_ptr_q] = pipe_idx_q[RD_LATENCY-1];
            wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        count_d = count_q + {1'b0, capture} - {1'b0, pop};

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d    = ST_FETCH;
                    dec_d      = iDecrypt;
                    round_d    = iRound;
                    addr_d     = 4'd0;
                    pipe_vld_d = '0;
                    wr_ptr_d   = 2'd0;
                    rd_ptr_d   = 2'd0;
                    count_d    = 2'd0;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    // The last address is not incremented so R=15 cannot wrap.
                    if (addr_q == round_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 4'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (head_idx == round_q)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q    <= ST_IDLE;
            dec_q      <= 1'b0;
            round_q    <= 4'd0;
            addr_q     <= 4'd0;
            done_q     <= 1'b0;
            pipe_vld_q <= '0;
            pipe_idx_q <= '{default: '0};
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            dec_q      <= dec_d;
            round_q    <= round_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_idx_q <= pipe_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
        fifo_key_q <= fifo_key_d;
        fifo_idx_q <= fifo_idx_d;
    end

    assign oBusy        = (state_q != ST_IDLE);
    assign oDone        = done_q;
    assign oRAM_Ke_addr = addr_q;
    assign oRAM_Kd_addr = addr_q;
    assign oRAM_Ke_read = issue & ~dec_q;
    assign oRAM_Kd_read = issue & dec_q;
    assign oValid       = (count_q != 2'd0);
    assign oKey         = oValid ? head_key : '0;
    assign oKey_idx     = oValid ? head_idx : '0;
    assign oDbg_state   = state_q;

endmodule

// File: tb/tb_roundkey_read_from_ram.sv
// Bench for roundkey_read_from_ram. Two instances run side by side on the
// same stimulus: dut0 with RD_LATENCY=1 and dut1 with RD_LATENCY=2, each
// with its own RAM model of matching latency over shared key contents.
module tb_roundkey_read_from_ram;

  localparam int ND = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       decrypt;
  logic [3:0] round;
  logic       ready;

  logic         busy    [ND];
  logic         done    [ND];
  logic [3:0]   ke_addr [ND];
  logic         ke_rd   [ND];
  logic [3:0]   kd_addr [ND];
  logic         kd_rd   [ND];
  logic [127:0] key     [ND];
  logic [3:0]   key_idx [ND];
  logic         valid   [ND];
  logic [1:0]   dbg     [ND];
  logic [31:0]  ke_q    [ND][4];
  logic [31:0]  kd_q    [ND][4];
  logic [31:0]  ke_s1   [4];
  logic [31:0]  kd_s1   [4];

  logic [31:0]  ke_mem  [4][16];
  logic [31:0]  kd_mem  [4][16];

  int total = 0;
  int bad   = 0;
  logic [131:0] exp_q[$];

  roundkey_read_from_ram #(.RD_LATENCY(1)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iDecrypt(decrypt), .iRound(round),
    .oBusy(busy[0]), .oDone(done[0]),
    .oRAM_Ke_addr(ke_addr[0]), .oRAM_Ke_read(ke_rd[0]),
    .iRAM_Ke_q_1(ke_q[0][0]), .iRAM_Ke_q_2(ke_q[0][1]), .iRAM_Ke_q_3(ke_q[0][2]), .iRAM_Ke_q_4(ke_q[0][3]),
    .oRAM_Kd_addr(kd_addr[0]), .oRAM_Kd_read(kd_rd[0]),
    .iRAM_Kd_q_1(kd_q[0][0]), .iRAM_Kd_q_2(kd_q[0][1]), .iRAM_Kd_q_3(kd_q[0][2]), .iRAM_Kd_q_4(kd_q[0][3]),
    .oKey(key[0]), .oKey_idx(key_idx[0]), .oValid(valid[0]), .iReady(ready), .oDbg_state(dbg[0])
  );

  roundkey_read_from_ram #(.RD_LATENCY(2)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start), .iDecrypt(decrypt), .iRound(round),
    .oBusy(busy[1]), .oDone(done[1]),
    .oRAM_Ke_addr(ke_addr[1]), .oRAM_Ke_read(ke_rd[1]),
    .iRAM_Ke_q_1(ke_q[1][0]), .iRAM_Ke_q_2(ke_q[1][1]), .iRAM_Ke_q_3(ke_q[1][2]), .iRAM_Ke_q_4(ke_q[1][3]),
    .oRAM_Kd_addr(kd_addr[1]), .oRAM_Kd_read(kd_rd[1]),
    .iRAM_Kd_q_1(kd_q[1][0]), .iRAM_Kd_q_2(kd_q[1][1]), .iRAM_Kd_q_3(kd_q[1][2]), .iRAM_Kd_q_4(kd_q[1][3]),
    .oKey(key[1]), .oKey_idx(key_idx[1]), .oValid(valid[1]), .iReady(ready), .oDbg_state(dbg[1])
  );

  // RAM models: data appears 1 (dut0) or 2 (dut1) cycles after the read strobe.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ke_rd[0]) ke_q[0][b] <= ke_mem[b][ke_addr[0]];
      if (kd_rd[0]) kd_q[0][b] <= kd_mem[b][kd_addr[0]];
      if (ke_rd[1]) ke_s1[b] <= ke_mem[b][ke_addr[1]];
      if (kd_rd[1]) kd_s1[b] <= kd_mem[b][kd_addr[1]];
      ke_q[1][b] <= ke_s1[b];
      kd_q[1][b] <= kd_s1[b];
    end
  end

  // ---------------- driver / checker tasks ----------------
  // Runs one key stream on both instances. Caller is 2 time units after an
  // edge. pre: start is raised immediately (in the cycle just sampled).
  task automatic run_stream(input string name, input logic dec, input logic [3:0] r,
                            input bit rnd, input bit mid, input bit pre);
    int issued [ND];
    int popped [ND];
    int last_pop [ND];
    int done_cyc [ND];
    logic prev_stall [ND];
    logic [131:0] prev_out [ND];
    logic [131:0] cur;
    int cyc;
    int lat;
    bit fin;
    logic exp_v, exp_d, exp_b, wrong, right;

    exp_q.delete();
    for (int i = 0; i <= int'(r); i++) begin
      if (dec) exp_q.push_back({4'(i), kd_mem[0][i], kd_mem[1][i], kd_mem[2][i], kd_mem[3][i]});
      else     exp_q.push_back({4'(i), ke_mem[0][i], ke_mem[1][i], ke_mem[2][i], ke_mem[3][i]});
    end
    for (int d = 0; d < ND; d++) begin
      issued[d] = 0; popped[d] = 0; last_pop[d] = -1; done_cyc[d] = -1;
      prev_stall[d] = 1'b0; prev_out[d] = '0;
    end

    if (!pre) #1;
    start = 1'b1; decrypt = dec; round = r;
    @(posedge clk);
    cyc = 1;
    fin = 0;
    while (!fin) begin
      #1;
      start = 1'b0;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 1) begin
        decrypt = 1'($urandom_range(0, 1));
        round   = 4'($urandom_range(0, 15));
      end
      if (mid && cyc == 5) begin
        start = 1'b1; decrypt = ~dec; round = r ^ 4'h5;
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        lat = d + 1;
        wrong = dec ? ke_rd[d] : kd_rd[d];
        right = dec ? kd_rd[d] : ke_rd[d];
        total++;
        if (wrong !== 1'b0) begin
          bad++; $display("FAIL %s dut%0d cyc%0d wrong_bank_strobe: got %b want 0", name, d, cyc, wrong);
        end
        total++;
        if (ke_addr[d] !== kd_addr[d]) begin
          bad++; $display("FAIL %s dut%0d cyc%0d addr_equal: ke %h kd %h", name, d, cyc, ke_addr[d], kd_addr[d]);
        end
        if (right === 1'b1) begin
          total++;
          if (issued[d] > int'(r) || ke_addr[d] !== 4'(issued[d])) begin
            bad++; $display("FAIL %s dut%0d cyc%0d read_addr: got %h want %0d (max %0d)", name, d, cyc, ke_addr[d], issued[d], r);
          end
          issued[d]++;
        end
        cur = {key_idx[d], key[d]};
        if (valid[d] === 1'b1) begin
          if (prev_stall[d]) begin
            total++;
            if (cur !== prev_out[d]) begin
              bad++; $display("FAIL %s dut%0d cyc%0d stall_stable: got %h want %h", name, d, cyc, cur, prev_out[d]);
            end
          end
          if (ready) begin
            total++;
            if (popped[d] > int'(r)) begin
              bad++; $display("FAIL %s dut%0d cyc%0d extra_key: got %h want none", name, d, cyc, cur);
            end else begin
              if (cur !== exp_q[popped[d]]) begin
                bad++; $display("FAIL %s dut%0d cyc%0d key: got %h want %h", name, d, cyc, cur, exp_q[popped[d]]);
              end
              popped[d]++;
              if (popped[d] == int'(r) + 1) last_pop[d] = cyc;
            end
          end
        end else if (prev_stall[d]) begin
          total++; bad++;
          $display("FAIL %s dut%0d cyc%0d valid_dropped: got %b want 1", name, d, cyc, valid[d]);
        end
        total++;
        if (issued[d] - popped[d] > lat + 1) begin
          bad++; $display("FAIL %s dut%0d cyc%0d credit: got %0d outstanding want <= %0d", name, d, cyc, issued[d] - popped[d], lat + 1);
        end
        if (!rnd) begin
          exp_v = (cyc >= lat + 2) && (cyc <= lat + 2 + int'(r));
          total++;
          if (valid[d] !== exp_v) begin
            bad++; $display("FAIL %s dut%0d cyc%0d valid_timing: got %b want %b", name, d, cyc, valid[d], exp_v);
          end
        end
        if (last_pop[d] >= 0 && cyc > last_pop[d]) begin
          total++;
          if (valid[d] !== 1'b0 || ke_rd[d] !== 1'b0 || kd_rd[d] !== 1'b0) begin
            bad++; $display("FAIL %s dut%0d cyc%0d quiet_after: got v%b rd%b%b want 000", name, d, cyc, valid[d], ke_rd[d], kd_rd[d]);
          end
        end
        exp_d = (last_pop[d] >= 0) && (cyc == last_pop[d] + 1);
        exp_b = !((last_pop[d] >= 0) && (cyc > last_pop[d]));
        total++;
        if (done[d] !== exp_d) begin
          bad++; $display("FAIL %s dut%0d cyc%0d done: got %b want %b", name, d, cyc, done[d], exp_d);
        end
        total++;
        if (busy[d] !== exp_b) begin
          bad++; $display("FAIL %s dut%0d cyc%0d busy: got %b want %b", name, d, cyc, busy[d], exp_b);
        end
        if (done[d] === 1'b1 && done_cyc[d] < 0) done_cyc[d] = cyc;
        prev_stall[d] = (valid[d] === 1'b1) && !ready;
        prev_out[d] = cur;
      end
      if ((done_cyc[0] >= 0 && done_cyc[1] >= 0) || cyc >= 300) fin = 1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      total++;
      if (done_cyc[d] < 0 || popped[d] != int'(r) + 1) begin
        bad++; $display("FAIL %s dut%0d completion: got %0d keys done_cyc %0d want %0d keys", name, d, popped[d], done_cyc[d], r + 1);
      end
    end
  endtask

  task automatic check_idle(input string name);
    for (int d = 0; d < ND; d++) begin
      total++;
      if ({busy[d], done[d], valid[d], ke_rd[d], kd_rd[d], ke_addr[d], kd_addr[d], key_idx[d], key[d]} !== '0) begin
        bad++;
        $display("FAIL %s dut%0d reset_values: got b%b d%b v%b rd%b%b a%h/%h i%h k%h want all 0", name, d,
                 busy[d], done[d], valid[d], ke_rd[d], kd_rd[d], ke_addr[d], kd_addr[d], key_idx[d], key[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; round = 4'd0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_encrypt();
    run_stream("encrypt_r10", 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_decrypt();
    run_stream("decrypt_r14", 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_stream("bp_enc_r10", 1'b0, 4'd10, 1'b1, 1'b0, 1'b0);
    run_stream("bp_dec_r10", 1'b1, 4'd10, 1'b1, 1'b0, 1'b0);
    run_stream("bp_dec_r13", 1'b1, 4'd13, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_round_zero();
    run_stream("r0_enc", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    run_stream("r0_dec_bp", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_round_max();
    run_stream("r15_enc", 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    run_stream("r15_dec_bp", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_stream("midstart_enc", 1'b0, 4'd10, 1'b0, 1'b1, 1'b0);
    run_stream("midstart_dec_bp", 1'b1, 4'd12, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_stream("b2b_first", 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    run_stream("b2b_second", 1'b1, 4'd5, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    #1;
    start = 1'b1; decrypt = 1'b0; round = 4'd10; ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_idle("reset_mid");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      check_idle("after_reset");
    end
    run_stream("restart_after_reset", 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        ke_mem[b][a] = 32'(a + 16 * b);
        kd_mem[b][a] = $urandom;
      end
    end
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_round_zero();
    test_round_max();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/roundkey_read_from_ram.md
# roundkey_read_from_ram

Reads expanded round keys back out of the four-bank encrypt (m_Ke) or decrypt (m_Kd) key RAMs after key expansion has filled them. Streams one 128-bit round key per round index, in ascending address order, to the cipher round datapath over a valid/ready handshake. A small return FIFO absorbs RAM read latency and consumer backpressure. It sits between the key RAMs and the round engine.

## Interface
Parameters:
- RD_LATENCY, 1, key RAM read latency in cycles (1 or 2); the return FIFO depth is RD_LATENCY+1.

Ports:
- iClk  in  1  single clock, all logic on rising edge.
- iRst_n  in  1  synchronous, active-low reset.
- iStart  in  1  one-cycle start pulse; ignored while oBusy=1.
- iDecrypt  in  1  0 selects Ke banks, 1 selects Kd banks; latched at start.
- iRound  in  4  last round index R; keys 0..R are read (R+1 keys); latched at start.
- oBusy  out  1  high when state is not IDLE.
- oDone  out  1  one-cycle pulse after the final key handshake.
- oRAM_Ke_addr  out  4  read address, Ke banks.
- oRAM_Ke_read  out  1  read strobe, all four Ke banks.
- iRAM_Ke_q_1..iRAM_Ke_q_4  in  32 each  Ke bank 1..4 read data.
- oRAM_Kd_addr  out  4  read address, Kd banks.
- oRAM_Kd_read  out  1  read strobe, all four Kd banks.
- iRAM_Kd_q_1..iRAM_Kd_q_4  in  32 each  Kd bank 1..4 read data.
- oKey  out  128  round key: [127:96]=q_1, [95:64]=q_2, [63:32]=q_3, [31:0]=q_4.
- oKey_idx  out  4  RAM address the presented key was read from.
- oValid  out  1  oKey/oKey_idx valid.
- iReady  in  1  consumer accepts the key when oValid & iReady.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE -> FETCH on iStart. The transition latches iDecrypt and iRound, clears issue counter a, in-flight count, and the FIFO.
- In FETCH, a read is issued at address a when inflight + fifo_count - pop_now < RD_LATENCY+1. On issue, a increments.
- Only the selected bank's read strobe asserts. Both address outputs carry a. The unselected strobe stays 0.
- FETCH -> DRAIN in the cycle the read for a=R issues. No further reads are issued.
- Read data is captured into the FIFO exactly RD_LATENCY cycles after the read was issued, with oKey_idx tagged from the issuing address.
- The FIFO head drives oKey, oKey_idx and oValid. The head pops on oValid & iReady.
- DRAIN -> IDLE on the handshake of key index R. oDone pulses in the following cycle.
- Decrypt order comes from how Kd was written: Kd address 0 holds the last encrypt key. The reader does no index reversal.
- Counters are 4-bit. R=15 gives 16 keys; a must stop and must not wrap.
- iStart while oBusy=1 is ignored with no effect on latched params.
- Reset (iRst_n=0 at any edge, including mid-operation) forces state IDLE, FIFO and in-flight cleared, and in-flight RAM data discarded.
- Reset values: oBusy=0, oDone=0, oValid=0, oKey=0, oKey_idx=0, both read strobes=0, both addresses=0.

## Timing
- iStart is sampled at edge 0; first read strobe is in cycle 1.
- With RD_LATENCY=1:
  - first oValid is in cycle 3;
  - with iReady held high, one key per cycle (keys in cycles 3..3+R);
  - oDone in cycle 4+R.
- With RD_LATENCY=2: first oValid is in cycle 4; full throughput is still one key per cycle.
- oValid holds and oKey is stable while iReady=0. No read issues when the credit is exhausted, so the FIFO never overflows.
- A pop and a capture in the same cycle are both honoured; count is unchanged.
- oBusy drops and oDone rises in the same cycle. A new iStart in the oDone cycle is accepted.

## Test plan
- Encrypt, R=10, iReady=1, RD_LATENCY=1, Ke[a] words = {a,a+16,a+32,a+48}:
  - 11 keys appear on consecutive cycles 3..13 with oKey_idx 0..10 and correct word order;
  - oDone in cycle 14; Kd strobe never asserts.
- Decrypt, R=14:
  - only oRAM_Kd_read toggles; keys idx 0..14 are read from Kd;
  - Ke strobe stays 0.
- Backpressure: R=10, iReady toggled pseudo-randomly:
  - no key lost or duplicated; oKey stable while oValid & ~iReady;
  - no read issues when inflight+count=2.
- Boundaries:
  - R=0 gives exactly one key, idx 0, then oDone;
  - R=15 gives 16 keys with no address wrap.
- iStart pulsed mid-stream with different iDecrypt and iRound: ignored; the stream completes with the original params.
- Reset mid-operation: iRst_n low for one cycle after key 3:
  - all outputs return to reset values and no stale key appears;
  - a new iStart runs cleanly from idx 0.
- Repeat the first scenario with RD_LATENCY=2: first oValid in cycle 4, one key per cycle.
